nibble_serial_adder_ctrl: RTL and testbench

//  Sequences one shared 4-bit full-adder slice (be_fa4) over NIBBLES nibbles to add wide operands.

---
 rtl/nsa_pkg.sv | 10 +
 rtl/be_fa4.sv | 12 +
 rtl/nibble_serial_adder_ctrl.sv | 90 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// nsa_pkg: shared constants and helpers for the nibble-serial adder controller
package nsa_pkg;
  localparam int NIB_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/be_fa4.sv
// be_fa4: 4-bit full-adder slice shared by all nibbles of the serial adder
module be_fa4
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds wide operands one nibble per clock through a single be_fa4 slice;
// defining NSA_SUB_EN adds a sub input that turns the operation into A - B.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef NSA_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int IW = idx_w(NIBBLES);
  logic [1:0]       state;
  logic [W-1:0]     a_r, b_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [NIB_W-1:0] a_n, b_n, s_n;
  logic             co_n, accept, last, carry_init;
`ifdef NSA_SUB_EN
  logic             sub_r;
`endif
  assign accept = start && (state != ST_RUN);
  assign last   = idx == IW'(NIBBLES - 1);
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;
  // Select the current operand nibbles; in subtract mode B is inverted and the carry seeds the +1
  always_comb begin
    a_n = a_r[idx*NIB_W +: NIB_W];
`ifdef NSA_SUB_EN
    b_n = sub_r ? ~b_r[idx*NIB_W +: NIB_W] : b_r[idx*NIB_W +: NIB_W];
    carry_init = sub ? 1'b1 : cin;
`else
    b_n = b_r[idx*NIB_W +: NIB_W];
    carry_init = cin;
`endif
  end
  be_fa4 u_fa4 (
    .a  (a_n),
    .b  (b_n),
    .ci (carry),
    .s  (s_n),
    .co (co_n)
  );
  // Control FSM: a start outside RUN always launches a new operation, DONE lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= accept ? ST_RUN : (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // Datapath: latch operands on accept, then fold one nibble per cycle into sum with a running carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      carry <= carry_init;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_RUN) begin
      sum[idx*NIB_W +: NIB_W] <= s_n;
      carry <= co_n;
      idx   <= idx + 1'b1;
      if (last) cout <= co_n;
    end
  end
`ifdef NSA_SUB_EN
  // Operation mode is captured together with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_r <= 1'b0;
    else if (accept) sub_r <= sub;
  end
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed checks of the nibble-serial adder with NIBBLES=4
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout;
  logic [15:0] sum;
`ifdef NSA_SUB_EN
  logic        sub = 1'b0;
`endif
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int rp, output int lat, output int np, output int bc,
                           output logic [15:0] s_at, output logic co_at);
    lat = -1; np = 0; bc = 0; s_at = 'x; co_at = 1'bx;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (busy) bc++;
      if (done) begin
        np++;
        if (lat < 0) begin lat = c; s_at = sum; co_at = cout; end
      end
      if (c == rp) begin start = 1'b1; a = 16'h0001; b = 16'h0001; end
      else if (c == rp + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #12;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (sum !== 16'h0000) begin nerr++; $display("FAIL reset_sum got %h exp 0000", sum); end
    nvec++; if (cout !== 1'b0) begin nerr++; $display("FAIL reset_cout got %b exp 0", cout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_add_basic;
    int lat, np, bc; logic [15:0] s; logic co;
    launch(16'h1234, 16'h4321, 1'b0);
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL basic_latency got %0d exp 4", lat); end
    nvec++; if (bc !== 4) begin nerr++; $display("FAIL basic_busy_cycles got %0d exp 4", bc); end
    nvec++; if (np !== 1) begin nerr++; $display("FAIL basic_done_pulses got %0d exp 1", np); end
    nvec++; if (s !== 16'h5555) begin nerr++; $display("FAIL basic_sum got %h exp 5555", s); end
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL basic_cout got %b exp 0", co); end
    nvec++; if (sum !== 16'h5555) begin nerr++; $display("FAIL basic_sum_held got %h exp 5555", sum); end
  endtask

  task automatic test_ripple;
    int lat, np, bc; logic [15:0] s; logic co;
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (np !== 1) begin nerr++; $display("FAIL ripple_done_pulses got %0d exp 1", np); end
    nvec++; if (s !== 16'h0000) begin nerr++; $display("FAIL ripple_sum got %h exp 0000", s); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL ripple_cout got %b exp 1", co); end
  endtask

  task automatic test_cin;
    int lat, np, bc; logic [15:0] s; logic co;
    launch(16'hFFFF, 16'h0000, 1'b1);
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (s !== 16'h0000) begin nerr++; $display("FAIL cin_sum got %h exp 0000", s); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL cin_cout got %b exp 1", co); end
    launch(16'h0F0E, 16'h1111, 1'b1);
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (s !== 16'h2020) begin nerr++; $display("FAIL cin_mixed_sum got %h exp 2020", s); end
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL cin_mixed_cout got %b exp 0", co); end
  endtask

  task automatic test_ignore_start;
    int lat, np, bc; logic [15:0] s; logic co;
    launch(16'h1000, 16'h0001, 1'b0);
    wait_done(1, lat, np, bc, s, co);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL ignore_latency got %0d exp 4", lat); end
    nvec++; if (np !== 1) begin nerr++; $display("FAIL ignore_done_pulses got %0d exp 1", np); end
    nvec++; if (s !== 16'h1001) begin nerr++; $display("FAIL ignore_sum got %h exp 1001", s); end
  endtask

  task automatic test_reset_mid_run;
    int lat, np, bc; logic [15:0] s; logic co;
    launch(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b exp 0", busy); end
    nvec++; if (sum !== 16'h0000) begin nerr++; $display("FAIL midrst_sum got %h exp 0000", sum); end
    nvec++; if (cout !== 1'b0) begin nerr++; $display("FAIL midrst_cout got %b exp 0", cout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    np = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) np++;
    end
    nvec++; if (np !== 0) begin nerr++; $display("FAIL midrst_done_pulses got %0d exp 0", np); end
    launch(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL postrst_latency got %0d exp 4", lat); end
    nvec++; if (s !== 16'h1000) begin nerr++; $display("FAIL postrst_sum got %h exp 1000", s); end
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL postrst_cout got %b exp 0", co); end
  endtask

  task automatic test_back_to_back;
    int lat, np, bc, k; logic [15:0] s; logic co;
    logic [15:0] a1, b1, e1, a2, b2, e2; logic c1, c2;
`ifdef NSA_SUB_EN
    sub = 1'b1;
    a1 = 16'h0005; b1 = 16'h0007; e1 = 16'hFFFE; c1 = 1'b0;
    a2 = 16'h0007; b2 = 16'h0005; e2 = 16'h0002; c2 = 1'b1;
`else
    a1 = 16'h00FF; b1 = 16'h0001; e1 = 16'h0100; c1 = 1'b0;
    a2 = 16'hFFFF; b2 = 16'hFFFF; e2 = 16'hFFFE; c2 = 1'b1;
`endif
    launch(a1, b1, 1'b0);
    k = 0;
    while (!done && k < 12) begin @(posedge clk); #1; k++; end
    nvec++; if (k !== 4) begin nerr++; $display("FAIL b2b_first_latency got %0d exp 4", k); end
    nvec++; if (sum !== e1) begin nerr++; $display("FAIL b2b_first_sum got %h exp %h", sum, e1); end
    nvec++; if (cout !== c1) begin nerr++; $display("FAIL b2b_first_cout got %b exp %b", cout, c1); end
    launch(a2, b2, 1'b0);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL b2b_accept_done got %b exp 0", done); end
    wait_done(-10, lat, np, bc, s, co);
    nvec++; if (np !== 1) begin nerr++; $display("FAIL b2b_second_pulses got %0d exp 1", np); end
    nvec++; if (s !== e2) begin nerr++; $display("FAIL b2b_second_sum got %h exp %h", s, e2); end
    nvec++; if (co !== c2) begin nerr++; $display("FAIL b2b_second_cout got %b exp %b", co, c2); end
`ifdef NSA_SUB_EN
    sub = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_basic();
    test_ripple();
    test_cin();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
